axis_overflow_buffer: RTL and testbench

//   Parametrised successor to the flag-only overflow detector, for a trace/packet stream source that cannot stall.

---
 rtl/axis_overflow_buffer.sv | 97 +++++++++
 tb/tb_axis_overflow_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_overflow_buffer.sv
// Non-stalling AXI-stream FIFO: drops beats while full, counts the drops and flags
// the next (or, in sticky mode, every later) stored beat by OR-ing FLAG_BIT into tdata.
module axis_overflow_buffer #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned FLAG_BIT = 31,
  parameter int unsigned CNT_W    = 16,
  parameter bit          STICKY   = 1'b0
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       input_axis_tvalid,
  output logic                       input_axis_tready,
  input  logic [DATA_W-1:0]          input_axis_tdata,
  output logic                       output_axis_tvalid,
  input  logic                       output_axis_tready,
  output logic [DATA_W-1:0]          output_axis_tdata,
  input  logic                       clear_stats,
  output logic [CNT_W-1:0]           drop_count,
  output logic                       overflow_active,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [$clog2(DEPTH):0]     high_water
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]  r_count;
  logic [LVL_W-1:0]  r_hw;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic              r_ovf;

  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [LVL_W-1:0]  w_count_next;
  logic [DATA_W-1:0] w_stored;
  logic              w_ovf_next;

  assign w_pop        = (r_count != '0) & output_axis_tready;
  // A full FIFO still accepts a beat when the head leaves on the same edge.
  assign w_push       = input_axis_tvalid & ((r_count < LVL_W'(DEPTH)) | w_pop);
  assign w_drop       = input_axis_tvalid & ~w_push;
  assign w_count_next = r_count + LVL_W'(w_push) - LVL_W'(w_pop);
  assign w_stored     = input_axis_tdata | (DATA_W'(r_ovf) << FLAG_BIT);

  always_comb begin
    w_ovf_next = r_ovf;
    if (w_drop) begin
      w_ovf_next = 1'b1;
    end else if (STICKY) begin
      if (clear_stats) w_ovf_next = 1'b0;
    end else if (w_push) begin
      w_ovf_next = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_stored;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_hw       <= '0;
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_ovf   <= w_ovf_next;
      if (clear_stats) begin
        r_hw       <= w_count_next;
        r_drop_cnt <= CNT_W'(w_drop);
      end else begin
        if (w_count_next > r_hw) r_hw <= w_count_next;
        if (w_drop && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign input_axis_tready  = 1'b1;
  assign output_axis_tvalid = (r_count != '0);
  // Gated so the output reads zero whenever the FIFO is empty, including after reset.
  assign output_axis_tdata  = output_axis_tvalid ? r_mem[r_rd_ptr] : '0;
  assign drop_count         = r_drop_cnt;
  assign overflow_active    = r_ovf;
  assign fifo_level         = r_count;
  assign high_water         = r_hw;

endmodule

// File: tb/tb_axis_overflow_buffer.sv
// Scoreboard bench: two instances (non-sticky/16-bit counter, sticky/4-bit counter) share
// one stimulus stream; a queue-based reference model predicts beats and status.
module tb_axis_overflow_buffer;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         in_tvalid = 1'b0;
  logic [127:0] in_tdata = '0;
  logic         out_tready = 1'b0;
  logic         clr = 1'b0;

  logic         itr   [2];
  logic         vld   [2];
  logic [127:0] dat   [2];
  logic         ovf   [2];
  logic [2:0]   lvl   [2];
  logic [2:0]   hw    [2];
  logic [15:0]  drop0;
  logic [3:0]   drop1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: p_* is the state the DUT will hold after the next edge, e_* the current one.
  int p_cnt [2], p_drop [2], p_hw [2];
  bit p_ovf [2];
  int e_cnt [2], e_drop [2], e_hw [2];
  bit e_ovf [2];
  logic [127:0] sb0[$];
  logic [127:0] sb1[$];

  always #5 aclk = ~aclk;

  axis_overflow_buffer #(.DATA_W(128), .DEPTH(4), .FLAG_BIT(31), .CNT_W(16), .STICKY(1'b0)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .input_axis_tvalid(in_tvalid), .input_axis_tready(itr[0]), .input_axis_tdata(in_tdata),
    .output_axis_tvalid(vld[0]), .output_axis_tready(out_tready), .output_axis_tdata(dat[0]),
    .clear_stats(clr), .drop_count(drop0), .overflow_active(ovf[0]),
    .fifo_level(lvl[0]), .high_water(hw[0])
  );

  axis_overflow_buffer #(.DATA_W(128), .DEPTH(4), .FLAG_BIT(31), .CNT_W(4), .STICKY(1'b1)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .input_axis_tvalid(in_tvalid), .input_axis_tready(itr[1]), .input_axis_tdata(in_tdata),
    .output_axis_tvalid(vld[1]), .output_axis_tready(out_tready), .output_axis_tdata(dat[1]),
    .clear_stats(clr), .drop_count(drop1), .overflow_active(ovf[1]),
    .fifo_level(lvl[1]), .high_water(hw[1])
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int d = 0; d < 2; d++) begin
        e_cnt[d] <= 0; e_drop[d] <= 0; e_hw[d] <= 0; e_ovf[d] <= 1'b0;
      end
    end else begin
      e_cnt <= p_cnt; e_drop <= p_drop; e_hw <= p_hw; e_ovf <= p_ovf;
    end
  end

  // Monitor: status every cycle, beat data on every handshake about to happen.
  always @(negedge aclk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [127:0] exp_beat;
        check($sformatf("tready%0d", d), 128'(itr[d]), 128'(1));
        check($sformatf("tvalid%0d", d), 128'(vld[d]), 128'(e_cnt[d] > 0));
        check($sformatf("level%0d", d), 128'(lvl[d]), 128'(e_cnt[d]));
        check($sformatf("hw%0d", d), 128'(hw[d]), 128'(e_hw[d]));
        check($sformatf("ovf%0d", d), 128'(ovf[d]), 128'(e_ovf[d]));
        check($sformatf("drop%0d", d), (d == 0) ? 128'(drop0) : 128'(drop1), 128'(e_drop[d]));
        if (vld[d] && out_tready) begin
          if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
            check($sformatf("sb_empty%0d", d), 128'(1), 128'(0));
          end else begin
            exp_beat = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            check($sformatf("tdata%0d", d), dat[d], exp_beat);
          end
        end
      end
    end
  end

  // Drive one cycle of inputs (called at posedge+1), advance the model, wait to next posedge+1.
  task automatic step(input bit tv, input logic [127:0] td, input bit tr, input bit c);
    in_tvalid = tv; in_tdata = td; out_tready = tr; clr = c;
    for (int d = 0; d < 2; d++) begin
      bit sticky  = (d == 1);
      int cap     = (d == 0) ? 65535 : 15;
      bit pop     = (p_cnt[d] > 0) && tr;
      bit push    = tv && ((p_cnt[d] < 4) || pop);
      bit drop    = tv && !push;
      logic [127:0] beat = td;
      if (p_ovf[d]) beat[31] = 1'b1;
      if (push) begin
        if (d == 0) sb0.push_back(beat); else sb1.push_back(beat);
      end
      p_cnt[d] = p_cnt[d] + int'(push) - int'(pop);
      if (drop) p_ovf[d] = 1'b1;
      else if (sticky ? c : push) p_ovf[d] = 1'b0;
      if (c) p_drop[d] = int'(drop);
      else if (drop && p_drop[d] < cap) p_drop[d]++;
      if (c || p_cnt[d] > p_hw[d]) p_hw[d] = p_cnt[d];
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      p_cnt[d] = 0; p_drop[d] = 0; p_hw[d] = 0; p_ovf[d] = 1'b0;
    end
    sb0.delete();
    sb1.delete();
  endtask

  task automatic do_reset();
    #2;
    aresetn = 1'b0;
    chk_en = 1'b0;
    in_tvalid = 1'b0; in_tdata = '0; out_tready = 1'b0; clr = 1'b0;
    model_clear();
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_tvalid%0d", d), 128'(vld[d]), 128'(0));
      check($sformatf("rst_tdata%0d", d), dat[d], 128'(0));
      check($sformatf("rst_level%0d", d), 128'(lvl[d]), 128'(0));
      check($sformatf("rst_hw%0d", d), 128'(hw[d]), 128'(0));
      check($sformatf("rst_ovf%0d", d), 128'(ovf[d]), 128'(0));
    end
    check("rst_drop0", 128'(drop0), 128'(0));
    check("rst_drop1", 128'(drop1), 128'(0));
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    chk_en = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    model_clear();
    @(posedge aclk);
    #1;
    do_reset();

    // Back-to-back with ready held high.
    for (int i = 0; i < 10; i++) step(1'b1, 128'h0a00 + 128'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("t1_drop0", 128'(drop0), 128'(0));
    check("t1_hw0", 128'(hw[0]), 128'(1));

    // Overfill with the sink stalled, then drain; beat 7 carries the mark.
    for (int i = 1; i <= 6; i++) step(1'b1, 128'(i), 1'b0, 1'b0);
    check("t2_drop0", 128'(drop0), 128'(2));
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 128'd7, 1'b1, 1'b0);
    step(1'b1, 128'd8, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Full FIFO with simultaneous pop and push.
    for (int i = 0; i < 4; i++) step(1'b1, 128'h900 + 128'(i), 1'b0, 1'b0);
    step(1'b1, 128'h9ff, 1'b1, 1'b0);
    check("t3_level0", 128'(lvl[0]), 128'(4));
    check("t3_drop0", 128'(drop0), 128'(2));

    // Clear, drain, then saturate the 4-bit counter.
    step(1'b0, '0, 1'b1, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) step(1'b1, 128'h500 + 128'(i), 1'b0, 1'b0);
    check("t5_drop1_sat", 128'(drop1), 128'(15));
    check("t5_drop0", 128'(drop0), 128'(20));
    step(1'b1, 128'h5ff, 1'b0, 1'b1);
    check("t5_clr_drop0", 128'(drop0), 128'(1));
    check("t5_clr_drop1", 128'(drop1), 128'(1));
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 128'h700 + 128'(i), 1'b1, 1'b0);

    // Reset with three beats buffered, then a clean stream again.
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 128'h300 + 128'(i), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 128'hb00 + 128'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("t6_hw0", 128'(hw[0]), 128'(1));

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 8), rnd128(), ($urandom_range(0, 9) < 5),
           ($urandom_range(0, 39) == 0));
    end
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
